// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// One bit period is the latched prescale count of CLK cycles; all frame settings are captured at acceptance.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t                state_q, state_next;
    logic [5:0]            cnt_q, cnt_next;
    logic [3:0]            bit_q, bit_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [5:0]            presc_q, presc_next;
    logic                  par_en_q, par_en_next;
    logic                  par_q, par_next;
    logic                  tx_next, busy_next;
    logic                  last_edge;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            presc_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_next;
            TX_OUT   <= tx_next;
            busy     <= busy_next;
            cnt_q    <= cnt_next;
            bit_q    <= bit_next;
            shift_q  <= shift_next;
            presc_q  <= presc_next;
            par_en_q <= par_en_next;
            par_q    <= par_next;
        end
    end

    // presc_q is never 0 outside IDLE, so P-1 cannot underflow where it matters
    assign last_edge = (cnt_q == presc_q - 6'd1);

    always_comb begin
        state_next  = state_q;
        tx_next     = TX_OUT;
        busy_next   = busy;
        cnt_next    = last_edge ? 6'd0 : cnt_q + 6'd1;
        bit_next    = bit_q;
        shift_next  = shift_q;
        presc_next  = presc_q;
        par_en_next = par_en_q;
        par_next    = par_q;

        case (state_q)
            IDLE: begin
                cnt_next  = '0;
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (Data_Valid) begin
                    state_next  = START;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                    bit_next    = '0;
                    shift_next  = P_DATA;
                    presc_next  = (prescale == 6'd0) ? 6'd1 : prescale;
                    par_en_next = PAR_EN;
                    par_next    = (^P_DATA) ^ PAR_TYP;
                end
            end
            START: begin
                if (last_edge) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (last_edge) begin
                    if (bit_q == LAST_DATA) begin
                        bit_next = '0;
                        if (par_en_q) begin
                            state_next = PARITY;
                            tx_next    = par_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // shift register keeps the next data bit at index 1
                        bit_next   = bit_q + 4'd1;
                        shift_next = shift_q >> 1;
                        tx_next    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_next = STOP;
                    bit_next   = '0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (last_edge) begin
                    if (bit_q == LAST_STOP) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        tx_next    = 1'b1;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx against a frame-level bit-list model.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int SB = 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    prescale;
    logic          TX_OUT;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_tx"}, 32'(TX_OUT), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd0);
        end
    endtask

    // Present one word and check every cycle of the resulting frame plus the idle cycle after it.
    // hold keeps Data_Valid high; disturb_at perturbs the inputs at that frame cycle;
    // abort_at asserts reset at that frame cycle and returns.
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps, input bit hold,
                        input int disturb_at, input int abort_at);
        logic frame[$];
        int   p;
        int   k;
        p = (ps == 6'd0) ? 1 : int'(ps);
        frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) frame.push_back(d[i]);
        if (pe) frame.push_back((^d) ^ pt);
        for (int i = 0; i < SB; i++) frame.push_back(1'b1);

        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        Data_Valid = 1'b1;
        k = 0;
        foreach (frame[b]) begin
            for (int c = 0; c < p; c++) begin
                tick();
                if (!hold) Data_Valid = 1'b0;
                check("frame_tx", 32'(TX_OUT), 32'(frame[b]));
                check("frame_busy", 32'(busy), 32'd1);
                if (k == abort_at) begin
                    RST = 1'b1;
                    tick();
                    check("abort_tx", 32'(TX_OUT), 32'd1);
                    check("abort_busy", 32'(busy), 32'd0);
                    RST = 1'b0;
                    return;
                end
                if (k == disturb_at) begin
                    Data_Valid = 1'b1;
                    P_DATA     = '1;
                    prescale   = 6'd3;
                    PAR_EN     = ~pe;
                    PAR_TYP    = ~pt;
                end
                k++;
            end
        end
        tick();
        check("end_tx", 32'(TX_OUT), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        tick();
        tick();
        check("reset_tx", 32'(TX_OUT), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        RST = 1'b0;
        check_idle("idle", 20);

        send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, -1, -1);
        check_idle("gap", 3);
        send(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0, -1, -1);
        check_idle("gap", 3);
        send(8'h00, 1'b0, 1'b0, 6'd16, 1'b0, -1, -1);
        check_idle("gap", 3);

        // mid-frame request and input changes must not touch the frame nor queue another
        send(8'h3C, 1'b1, 1'b0, 6'd4, 1'b0, 20, -1);
        check_idle("no_second", 20);

        send(8'h5A, 1'b1, 1'b0, 6'd8, 1'b0, -1, 30);
        check_idle("post_abort", 5);
        send(8'hC3, 1'b1, 1'b1, 6'd8, 1'b0, -1, -1);
        check_idle("gap", 2);

        // prescale 0 behaves as 1
        send(8'h96, 1'b1, 1'b0, 6'd0, 1'b0, -1, -1);
        check_idle("gap", 2);

        // back-to-back: a single idle cycle separates frames
        send(8'h12, 1'b0, 1'b0, 6'd3, 1'b1, -1, -1);
        send(8'hE7, 1'b1, 1'b1, 6'd3, 1'b0, -1, -1);
        check_idle("gap", 2);

        for (int n = 0; n < 12; n++) begin
            send(DW'($urandom), 1'($urandom), 1'($urandom),
                 6'($urandom_range(0, 7)), 1'b0, -1, -1);
            check_idle("rand_gap", int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
